uart_alu_ctrl: RTL and testbench

//  Command initiator for the ALU in the UART-ALU system. Assembles a 3-byte frame from UART RX: opcode, A, B.

---
 rtl/uart_alu_ctrl_pkg.sv | 34 +++
 rtl/uart_alu_ctrl_txser.sv | 51 +++++
 rtl/uart_alu_ctrl.sv | 126 ++++++++++++
 tb/tb_uart_alu_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_ctrl_pkg.sv
// Shared types for the UART-ALU command controller.
// ALU opcodes, controller states and width constants.
package uart_alu_ctrl_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int RESULT_W   = 2 * DATA_WIDTH;
  localparam int OPC_MAX    = 11;

  typedef enum logic [3:0] {
    Addition       = 4'd0,
    Subtraction    = 4'd1,
    Multiplication = 4'd2,
    Division       = 4'd3,
    AND_e          = 4'd4,
    OR_e           = 4'd5,
    NAND_e         = 4'd6,
    NOR_e          = 4'd7,
    XOR_e          = 4'd8,
    CMPH           = 4'd9,
    SHIFTL         = 4'd10,
    SHIFTR         = 4'd11
  } Alu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    ISSUE,
    WAIT_RES,
    SEND_LO,
    SEND_HI
  } ctrl_state_e;

endpackage

// File: rtl/uart_alu_ctrl_txser.sv
// Result serialiser: emits a 2*DW result as lo then hi byte
// over a valid/busy handshake, with an idle cycle between bytes.
module uart_alu_ctrl_txser #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      load,
  input  logic [2*DATA_WIDTH-1:0]   result,
  input  logic                      TX_BUSY,
  output logic [DATA_WIDTH-1:0]     TX_P_DATA,
  output logic                      TX_D_VLD,
  output logic                      acc
);
  import uart_alu_ctrl_pkg::*;

  localparam int RW = 2 * DATA_WIDTH;

  logic [RW-1:0] res;
  logic          hi;
  logic          gap;
  logic          vld;

  assign acc       = vld && !TX_BUSY;
  assign TX_D_VLD  = vld;
  assign TX_P_DATA = hi ? res[RW-1:DATA_WIDTH]
                        : res[DATA_WIDTH-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      res <= '0;
      hi  <= 1'b0;
      gap <= 1'b0;
      vld <= 1'b0;
    end else if (load) begin
      res <= result;
      hi  <= 1'b0;
      gap <= 1'b0;
      vld <= 1'b1;
    end else if (acc) begin
      // after the lo byte, insert one idle cycle then show hi
      vld <= 1'b0;
      gap <= !hi;
      hi  <= !hi;
    end else if (gap) begin
      vld <= 1'b1;
      gap <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// UART-ALU command controller: RX frame (op, A, B) -> ALU -> TX lo/hi.
// Optional macro ALU_DIV0_CHECK_EN short-circuits division by zero.
module uart_alu_ctrl #(
  parameter int DATA_WIDTH   = uart_alu_ctrl_pkg::DATA_WIDTH,
  parameter int RESP_TIMEOUT = 15
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
  input  logic                      RX_D_VLD,
  output logic [DATA_WIDTH-1:0]     ALU_A,
  output logic [DATA_WIDTH-1:0]     ALU_B,
  output logic [3:0]                ALU_FUN,
  output logic                      ALU_EN,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                      ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]     TX_P_DATA,
  output logic                      TX_D_VLD,
  input  logic                      TX_BUSY,
  output logic                      BUSY,
  output logic                      ERR
);
  import uart_alu_ctrl_pkg::*;

  localparam int RW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(RESP_TIMEOUT + 1);

  ctrl_state_e   state;
  ctrl_state_e   state_nxt;
  logic [CW-1:0] cnt;
  logic          tx_load;
  logic [RW-1:0] tx_res;
  logic          tx_acc;
  logic          opc_bad;
  logic          div0;

  assign opc_bad = RX_P_DATA > DATA_WIDTH'(OPC_MAX);
  assign BUSY    = state != IDLE;

`ifdef ALU_DIV0_CHECK_EN
  assign div0 = (ALU_FUN == 4'(Division)) && (ALU_B == '0);
`else
  assign div0 = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ALU_EN    = 1'b0;
    ERR       = 1'b0;
    tx_load   = 1'b0;
    tx_res    = ALU_OUT;
    unique case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (opc_bad) ERR = 1'b1;
          else state_nxt = GET_A;
        end
      end
      GET_A: if (RX_D_VLD) state_nxt = GET_B;
      GET_B: if (RX_D_VLD) state_nxt = ISSUE;
      ISSUE: begin
        ERR = RX_D_VLD;
        if (div0) begin
          ERR       = 1'b1;
          tx_load   = 1'b1;
          tx_res    = '1;
          state_nxt = SEND_LO;
        end else begin
          ALU_EN    = 1'b1;
          state_nxt = WAIT_RES;
        end
      end
      WAIT_RES: begin
        ERR = RX_D_VLD;
        if (ALU_OUT_VLD) begin
          tx_load   = 1'b1;
          state_nxt = SEND_LO;
        end else if (cnt == CW'(RESP_TIMEOUT)) begin
          ERR       = 1'b1;
          state_nxt = IDLE;
        end
      end
      SEND_LO: begin
        ERR = RX_D_VLD;
        if (tx_acc) state_nxt = SEND_HI;
      end
      SEND_HI: begin
        ERR = RX_D_VLD;
        if (tx_acc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      ALU_A   <= '0;
      ALU_B   <= '0;
      ALU_FUN <= 4'(Addition);
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && RX_D_VLD) ALU_FUN <= RX_P_DATA[3:0];
      if (state == GET_A && RX_D_VLD) ALU_A <= RX_P_DATA;
      if (state == GET_B && RX_D_VLD) ALU_B <= RX_P_DATA;
      // cnt equals cycles elapsed since ALU_EN while waiting
      if (state == ISSUE) cnt <= CW'(1);
      else if (state == WAIT_RES) cnt <= cnt + CW'(1);
    end
  end

  uart_alu_ctrl_txser #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_txser (
    .CLK       (CLK),
    .RST       (RST),
    .load      (tx_load),
    .result    (tx_res),
    .TX_BUSY   (TX_BUSY),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VLD  (TX_D_VLD),
    .acc       (tx_acc)
  );

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl: directed frames, queued TX bytes,
// ALU responder model, timeout, backpressure, div-by-zero and reset cases.
module tb_uart_alu_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY = 1'b0;
  logic        BUSY;
  logic        ERR;

  uart_alu_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_P_DATA   (RX_P_DATA),
    .RX_D_VLD    (RX_D_VLD),
    .ALU_A       (ALU_A),
    .ALU_B       (ALU_B),
    .ALU_FUN     (ALU_FUN),
    .ALU_EN      (ALU_EN),
    .ALU_OUT     (ALU_OUT),
    .ALU_OUT_VLD (ALU_OUT_VLD),
    .TX_P_DATA   (TX_P_DATA),
    .TX_D_VLD    (TX_D_VLD),
    .TX_BUSY     (TX_BUSY),
    .BUSY        (BUSY),
    .ERR         (ERR)
  );

  always #5 CLK = ~CLK;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         err_cnt = 0;
  int         en_cnt  = 0;
  logic [7:0] exp_q[$];
  logic       alu_mute = 1'b0;
  int         alu_dly  = 0;
  logic       s_err;
  logic       s_busy;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_f(input logic [3:0] f,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    case (f)
      4'd0: return {8'h00, a} + {8'h00, b};
      4'd1: return {8'h00, a} - {8'h00, b};
      4'd2: return 16'(a) * 16'(b);
      4'd3: return (b == 8'h00) ? 16'h1234 : 16'(a / b);
      default: return 16'h0000;
    endcase
  endfunction

  // ALU responder: result alu_dly+1 cycles after ALU_EN
  initial forever begin
    logic [3:0] rf;
    logic [7:0] ra;
    logic [7:0] rb;
    @(negedge CLK);
    if (ALU_EN && !alu_mute) begin
      rf = ALU_FUN;
      ra = ALU_A;
      rb = ALU_B;
      repeat (alu_dly) @(posedge CLK);
      @(posedge CLK); #1;
      ALU_OUT_VLD = 1'b1;
      ALU_OUT     = alu_f(rf, ra, rb);
      @(posedge CLK); #1;
      ALU_OUT_VLD = 1'b0;
      ALU_OUT     = '0;
    end
  end

  // TX monitor / scoreboard
  initial begin
    logic       hold_q = 1'b0;
    logic       acc_q  = 1'b0;
    logic [7:0] data_q = '0;
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      if (ERR) err_cnt++;
      if (ALU_EN) en_cnt++;
      if (hold_q) begin
        chk("tx_hold_vld", 32'(TX_D_VLD), 32'd1);
        chk("tx_hold_data", 32'(TX_P_DATA), 32'(data_q));
      end
      if (acc_q) chk("tx_gap", 32'(TX_D_VLD), 32'd0);
      if (TX_D_VLD && !TX_BUSY) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_unexpected: got %0h expected none", TX_P_DATA);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'(TX_P_DATA), 32'(e));
        end
      end
      hold_q = TX_D_VLD && TX_BUSY;
      acc_q  = TX_D_VLD && !TX_BUSY;
      data_q = TX_P_DATA;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    s_err  = ERR;
    s_busy = BUSY;
    @(posedge CLK); #1;
    RX_D_VLD = 1'b0;
  endtask

  task automatic frame(input logic [7:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    send_byte(op);
    send_byte(a);
    send_byte(b);
  endtask

  task automatic wait_idle(input string name);
    logic done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge CLK);
      done = !BUSY && exp_q.size() == 0;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_busy"}, 32'(BUSY), 32'd0);
    chk({name, "_a"}, 32'(ALU_A), 32'd0);
    chk({name, "_b"}, 32'(ALU_B), 32'd0);
    chk({name, "_fun"}, 32'(ALU_FUN), 32'd0);
    chk({name, "_en"}, 32'(ALU_EN), 32'd0);
    chk({name, "_txv"}, 32'(TX_D_VLD), 32'd0);
    chk({name, "_txd"}, 32'(TX_P_DATA), 32'd0);
    chk({name, "_err"}, 32'(ERR), 32'd0);
  endtask

  initial begin
    int e0;
    int n0;
    int k;
    logic seen;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset("reset");
    @(posedge CLK); #1;
    RST = 1'b0;

    // 1: multiply with latency check
    e0 = err_cnt; n0 = en_cnt;
    exp_q.push_back(8'hE1); exp_q.push_back(8'h00);
    frame(8'h02, 8'h0F, 8'h0F);
    @(negedge CLK); chk("mul_en_b1", 32'(ALU_EN), 32'd1);
    @(negedge CLK); chk("mul_txv_b2", 32'(TX_D_VLD), 32'd0);
    @(negedge CLK); chk("mul_txv_b3", 32'(TX_D_VLD), 32'd1);
    wait_idle("mul_done");
    chk("mul_en_cnt", 32'(en_cnt - n0), 32'd1);
    chk("mul_err", 32'(err_cnt - e0), 32'd0);

    // 2: subtract and add with carry
    e0 = err_cnt;
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
    frame(8'h01, 8'h05, 8'h07);
    wait_idle("sub_done");
    exp_q.push_back(8'hFE); exp_q.push_back(8'h01);
    frame(8'h00, 8'hFF, 8'hFF);
    wait_idle("add_done");
    chk("addsub_err", 32'(err_cnt - e0), 32'd0);

    // 3: illegal opcodes then a good frame
    e0 = err_cnt;
    send_byte(8'h0C);
    chk("ill_err", 32'(s_err), 32'd1);
    chk("ill_busy", 32'(s_busy), 32'd0);
    send_byte(8'h10);
    chk("ill10_err", 32'(s_err), 32'd1);
    @(negedge CLK); chk("ill_busy_after", 32'(BUSY), 32'd0);
    exp_q.push_back(8'h03); exp_q.push_back(8'h00);
    frame(8'h00, 8'h01, 8'h02);
    wait_idle("ill_recover");
    chk("ill_err_cnt", 32'(err_cnt - e0), 32'd2);

    // 4: TX backpressure
    TX_BUSY = 1'b1;
    exp_q.push_back(8'h30); exp_q.push_back(8'h00);
    frame(8'h00, 8'h10, 8'h20);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      seen = TX_D_VLD;
    end
    chk("bp_txv_seen", 32'(seen), 32'd1);
    repeat (20) @(posedge CLK);
    #1 TX_BUSY = 1'b0;
    wait_idle("bp_done");

    // 5a: response timeout
    e0 = err_cnt;
    alu_mute = 1'b1;
    frame(8'h00, 8'h01, 8'h01);
    @(negedge CLK); chk("to_en", 32'(ALU_EN), 32'd1);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(negedge CLK);
      if (ERR) k = i;
    end
    chk("to_err_cycle", 32'(k), 32'd15);
    @(negedge CLK); chk("to_idle", 32'(BUSY), 32'd0);
    chk("to_err_cnt", 32'(err_cnt - e0), 32'd1);
    alu_mute = 1'b0;
    repeat (5) @(posedge CLK);

    // 5b: stray RX during WAIT_RES
    e0 = err_cnt;
    alu_dly = 5;
    exp_q.push_back(8'h0F); exp_q.push_back(8'h00);
    frame(8'h00, 8'h07, 8'h08);
    @(posedge CLK); #1;
    send_byte(8'h55);
    chk("stray_err", 32'(s_err), 32'd1);
    chk("stray_busy", 32'(s_busy), 32'd1);
    wait_idle("stray_done");
    chk("stray_err_cnt", 32'(err_cnt - e0), 32'd1);
    alu_dly = 0;

    // 6: division, normal and by zero
    exp_q.push_back(8'h04); exp_q.push_back(8'h00);
    frame(8'h03, 8'h10, 8'h04);
    wait_idle("div_done");
    e0 = err_cnt; n0 = en_cnt;
`ifdef ALU_DIV0_CHECK_EN
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    frame(8'h03, 8'h10, 8'h00);
    wait_idle("div0_done");
    chk("div0_en", 32'(en_cnt - n0), 32'd0);
    chk("div0_err", 32'(err_cnt - e0), 32'd1);
`else
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    frame(8'h03, 8'h10, 8'h00);
    wait_idle("div0_done");
    chk("div0_en", 32'(en_cnt - n0), 32'd1);
    chk("div0_err", 32'(err_cnt - e0), 32'd0);
`endif

    // reset mid GET_B discards the partial frame
    send_byte(8'h02);
    send_byte(8'h0A);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk_reset("rst_mid");
    exp_q.push_back(8'h05); exp_q.push_back(8'h00);
    frame(8'h00, 8'h02, 8'h03);
    wait_idle("rst_recover");

    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
